// File: rtl/video_mnist_class_argmax_pkg.sv
// Shared constants and width helpers for the MNIST class argmax back end.
package video_mnist_class_argmax_pkg;

  localparam int unsigned DEF_TUSER_WIDTH = 1;
  localparam int unsigned DEF_NUM_CLASS   = 10;
  localparam int unsigned DEF_VOTE_NUM    = 8;

  // Ceiling log2; 0 and 1 both map to 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic int unsigned count_width(input int unsigned vote_num);
    return clog2(vote_num + 1);
  endfunction

  function automatic int unsigned class_width(input int unsigned num_class);
    return (num_class > 1) ? clog2(num_class) : 1;
  endfunction

endpackage

// File: rtl/video_mnist_class_argmax_if.sv
// Input vote stream and output classification stream of the argmax block.
interface video_mnist_class_argmax_if
  import video_mnist_class_argmax_pkg::*;
#(
  parameter int unsigned TUSER_WIDTH   = DEF_TUSER_WIDTH,
  parameter int unsigned S_TDATA_WIDTH = DEF_NUM_CLASS * DEF_VOTE_NUM,
  parameter int unsigned CLASS_WIDTH   = class_width(DEF_NUM_CLASS),
  parameter int unsigned COUNT_WIDTH   = count_width(DEF_VOTE_NUM)
);

  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser;
  logic                     s_axi4s_tlast;
  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata;
  logic                     s_axi4s_tvalid;
  logic                     s_axi4s_tready;

  logic [TUSER_WIDTH-1:0]   m_axi4s_tuser;
  logic                     m_axi4s_tlast;
  logic [CLASS_WIDTH-1:0]   m_axi4s_tclass;
  logic [COUNT_WIDTH-1:0]   m_axi4s_tcount;
  logic                     m_axi4s_tdetect;
  logic                     m_axi4s_tvalid;
  logic                     m_axi4s_tready;

  // Environment side: produces votes, consumes classifications.
  modport master (
    output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
    input  s_axi4s_tready,
    input  m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tclass, m_axi4s_tcount,
           m_axi4s_tdetect, m_axi4s_tvalid,
    output m_axi4s_tready
  );

  // Block side.
  modport slave (
    input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tvalid,
    output s_axi4s_tready,
    output m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tclass, m_axi4s_tcount,
           m_axi4s_tdetect, m_axi4s_tvalid,
    input  m_axi4s_tready
  );

endinterface

// File: rtl/video_mnist_popcount.sv
// Combinational population count of one class's binary vote group.
module video_mnist_popcount
  import video_mnist_class_argmax_pkg::*;
#(
  parameter int unsigned VOTE_NUM    = DEF_VOTE_NUM,
  parameter int unsigned COUNT_WIDTH = count_width(VOTE_NUM)
) (
  input  logic [VOTE_NUM-1:0]    votes,
  output logic [COUNT_WIDTH-1:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < VOTE_NUM; i++) begin
      count_c = count_c + COUNT_WIDTH'(votes[i]);
    end
  end

endmodule

// File: rtl/video_mnist_class_argmax.sv
// Per-pixel class vote popcount, argmax and threshold detect; two-stage
// AXI4-Stream pipeline with full backpressure.
module video_mnist_class_argmax
  import video_mnist_class_argmax_pkg::*;
#(
  parameter int unsigned TUSER_WIDTH   = DEF_TUSER_WIDTH,
  parameter int unsigned NUM_CLASS     = DEF_NUM_CLASS,
  parameter int unsigned VOTE_NUM      = DEF_VOTE_NUM,
  parameter int unsigned S_TDATA_WIDTH = NUM_CLASS * VOTE_NUM,
  parameter int unsigned COUNT_WIDTH   = count_width(VOTE_NUM),
  parameter int unsigned CLASS_WIDTH   = class_width(NUM_CLASS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] param_threshold,
  input  logic                   param_enable,
  video_mnist_class_argmax_if.slave bus
);

  logic                     cke_c;
  logic                     sof_hs_c;
  logic [S_TDATA_WIDTH-1:0] votes_c;
  logic [COUNT_WIDTH-1:0]   cnt_c [NUM_CLASS];
  logic [COUNT_WIDTH-1:0]   thr_sel_c;
  logic                     en_sel_c;

  logic [COUNT_WIDTH-1:0]   thr_q;
  logic                     en_q;

  logic                     st1_valid;
  logic [TUSER_WIDTH-1:0]   st1_user;
  logic                     st1_last;
  logic [COUNT_WIDTH-1:0]   st1_cnt [NUM_CLASS];
  logic [COUNT_WIDTH-1:0]   st1_thr;
  logic                     st1_en;

  logic [CLASS_WIDTH-1:0]   best_cls_c;
  logic [COUNT_WIDTH-1:0]   best_cnt_c;

  // Whole pipeline advances together whenever the output slot can move.
  assign cke_c              = ~bus.m_axi4s_tvalid | bus.m_axi4s_tready;
  assign bus.s_axi4s_tready = cke_c;
  assign votes_c            = bus.s_axi4s_tdata;
  assign sof_hs_c           = bus.s_axi4s_tvalid & cke_c & bus.s_axi4s_tuser[0];

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_pc
    video_mnist_popcount #(
      .VOTE_NUM    (VOTE_NUM),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_popcount (
      .votes   (votes_c[c*VOTE_NUM +: VOTE_NUM]),
      .count_c (cnt_c[c])
    );
  end

  // The SOF beat itself already uses the freshly sampled params; they then
  // travel with each beat so a new frame cannot retag older in-flight pixels.
  assign thr_sel_c = sof_hs_c ? param_threshold : thr_q;
  assign en_sel_c  = sof_hs_c ? param_enable    : en_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q <= '0;
      en_q  <= 1'b0;
    end else if (sof_hs_c) begin
      thr_q <= param_threshold;
      en_q  <= param_enable;
    end
  end

  // Stage 1: popcounts, sideband and frame params.
  always_ff @(posedge clk) begin
    if (reset) begin
      st1_valid <= 1'b0;
      st1_user  <= '0;
      st1_last  <= 1'b0;
      st1_thr   <= '0;
      st1_en    <= 1'b0;
      for (int unsigned c = 0; c < NUM_CLASS; c++) st1_cnt[c] <= '0;
    end else if (cke_c) begin
      st1_valid <= bus.s_axi4s_tvalid;
      st1_user  <= bus.s_axi4s_tuser;
      st1_last  <= bus.s_axi4s_tlast;
      st1_thr   <= thr_sel_c;
      st1_en    <= en_sel_c;
      st1_cnt   <= cnt_c;
    end
  end

  // Strict greater-than scan keeps the lowest class index on ties.
  always_comb begin
    best_cls_c = '0;
    best_cnt_c = st1_cnt[0];
    for (int unsigned c = 1; c < NUM_CLASS; c++) begin
      if (st1_cnt[c] > best_cnt_c) begin
        best_cls_c = CLASS_WIDTH'(c);
        best_cnt_c = st1_cnt[c];
      end
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m_axi4s_tvalid  <= 1'b0;
      bus.m_axi4s_tuser   <= '0;
      bus.m_axi4s_tlast   <= 1'b0;
      bus.m_axi4s_tclass  <= '0;
      bus.m_axi4s_tcount  <= '0;
      bus.m_axi4s_tdetect <= 1'b0;
    end else if (cke_c) begin
      bus.m_axi4s_tvalid  <= st1_valid;
      bus.m_axi4s_tuser   <= st1_user;
      bus.m_axi4s_tlast   <= st1_last;
      bus.m_axi4s_tclass  <= best_cls_c;
      bus.m_axi4s_tcount  <= best_cnt_c;
      bus.m_axi4s_tdetect <= st1_en & (best_cnt_c >= st1_thr);
    end
  end

endmodule
